// File: rtl/cpu_dcache_write_buffer.sv
// Posted-write FIFO between the CPU memory stage and the data cache.
// Store-to-load forwarding is built only when CPU_WB_FORWARD_EN is defined.
module cpu_dcache_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_request,
  input  logic          i_rw,
  input  logic          i_flush,
  input  logic [AW-1:0] i_address,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_cacheable,
  output logic          o_ready,
  output logic [DW-1:0] o_rdata,
  output logic          o_empty,
  output logic          o_dc_request,
  output logic          o_dc_rw,
  output logic          o_dc_flush,
  output logic [AW-1:0] o_dc_address,
  output logic [DW-1:0] o_dc_wdata,
  output logic          o_dc_cacheable,
  input  logic          i_dc_ready,
  input  logic [DW-1:0] i_dc_rdata
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_WAIT,
    S_READ,
    S_FLUSH,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] cach_q;
  logic [PW-1:0]    head_q, tail_q;
  logic [PW:0]      count_q;
  logic             drain_q, ack_q, ack_d;
  logic [DW-1:0]    rdata_q;

  logic fifo_empty, fifo_full;
  logic cpu_flush, cpu_read, cpu_write;
  logic open, drain_en, push, pop;
  logic fwd_hit, fwd_ok;
  logic [DW-1:0] fwd_data;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PW+1)'(DEPTH));

  // o_ready masks the request still held during its own completion cycle
  assign cpu_flush = i_flush && !o_ready;
  assign cpu_read  = i_request && !i_rw && !i_flush && !o_ready;
  assign cpu_write = i_request && i_rw && !i_flush && !o_ready;

  assign open     = (state_q == S_IDLE) || (state_q == S_DRAIN);
  assign drain_en = open || (state_q == S_WAIT);
  assign push     = open && cpu_write && !fifo_full;
  assign pop      = drain_q && i_dc_ready;

`ifdef CPU_WB_FORWARD_EN
  logic [PW-1:0] fwd_idx;

  // Scan oldest to youngest so the last match wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PW'(k);
      if (((PW+1)'(k) < count_q) &&
          (addr_q[fwd_idx] == i_address)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  assign fwd_ok = open && cpu_read && i_cacheable && fwd_hit;

  always_comb begin
    state_d = state_q;
    ack_d   = push || fwd_ok;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty)
          state_d = S_DRAIN;
        else if (cpu_flush || (cpu_read && !fwd_ok))
          state_d = S_WAIT;
      end
      S_DRAIN: begin
        if (fifo_empty)
          state_d = S_IDLE;
      end
      S_WAIT: begin
        if (fifo_empty && !drain_q)
          state_d = i_flush ? S_FLUSH : S_READ;
      end
      S_READ: begin
        if (i_dc_ready)
          state_d = S_RESP;
      end
      S_FLUSH: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drain_q <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      if (push)
        tail_q <= tail_q + PW'(1);
      if (pop)
        head_q <= head_q + PW'(1);
      if (push && !pop)
        count_q <= count_q + (PW+1)'(1);
      else if (pop && !push)
        count_q <= count_q - (PW+1)'(1);
      // Dropping on pop forces a one-cycle gap between entries
      if (pop)
        drain_q <= 1'b0;
      else if (!drain_q && !fifo_empty && drain_en)
        drain_q <= 1'b1;
      if ((state_q == S_READ) && i_dc_ready)
        rdata_q <= i_dc_rdata;
      else if (fwd_ok)
        rdata_q <= fwd_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (push) begin
      addr_q[tail_q] <= i_address;
      data_q[tail_q] <= i_wdata;
      cach_q[tail_q] <= i_cacheable;
    end
  end

  assign o_ready      = ack_q || (state_q == S_RESP);
  assign o_rdata      = rdata_q;
  assign o_dc_request = drain_q || (state_q == S_READ);
  assign o_dc_rw      = drain_q;
  assign o_dc_flush   = (state_q == S_FLUSH);
  assign o_empty      = fifo_empty && !o_dc_request;

  assign o_dc_address =
    drain_q              ? addr_q[head_q] :
    (state_q == S_READ)  ? i_address      : '0;
  assign o_dc_wdata   = drain_q ? data_q[head_q] : '0;
  assign o_dc_cacheable =
    drain_q ? cach_q[head_q] :
    ((state_q == S_READ) && i_cacheable);

endmodule

// File: tb/tb_cpu_dcache_write_buffer.sv
// Random and directed bench for cpu_dcache_write_buffer.
// Reference: flat program-order memory plus the ordered list of stores.
module tb_cpu_dcache_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
`ifdef CPU_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_request = 1'b0;
  logic          i_rw = 1'b0;
  logic          i_flush = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [DW-1:0] i_wdata = '0;
  logic          i_cacheable = 1'b0;
  logic          o_ready;
  logic [DW-1:0] o_rdata;
  logic          o_empty;
  logic          o_dc_request;
  logic          o_dc_rw;
  logic          o_dc_flush;
  logic [AW-1:0] o_dc_address;
  logic [DW-1:0] o_dc_wdata;
  logic          o_dc_cacheable;
  logic          i_dc_ready = 1'b0;
  logic [DW-1:0] i_dc_rdata = '0;

  cpu_dcache_write_buffer #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW)
  ) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_request      (i_request),
    .i_rw           (i_rw),
    .i_flush        (i_flush),
    .i_address      (i_address),
    .i_wdata        (i_wdata),
    .i_cacheable    (i_cacheable),
    .o_ready        (o_ready),
    .o_rdata        (o_rdata),
    .o_empty        (o_empty),
    .o_dc_request   (o_dc_request),
    .o_dc_rw        (o_dc_rw),
    .o_dc_flush     (o_dc_flush),
    .o_dc_address   (o_dc_address),
    .o_dc_wdata     (o_dc_wdata),
    .o_dc_cacheable (o_dc_cacheable),
    .i_dc_ready     (i_dc_ready),
    .i_dc_rdata     (i_dc_rdata)
  );

  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cache model state
  bit            model_en = 1'b1;
  bit            cache_hold = 1'b0;
  int            cache_lat = 1;
  int            wait_n = 0;
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [AW-1:0] wlog_a [$];
  logic [DW-1:0] wlog_d [$];
  int            wlog_c [$];
  int            n_reads = 0;
  int            n_flush = 0;
  int            flush_cyc = 0;
  int            flush_wlog = 0;
  int            max_out = 0;

  // Reference state
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [AW-1:0] exp_a [$];
  logic [DW-1:0] exp_d [$];
  int            n_acked = 0;

  initial begin
    forever begin
      @(posedge i_clock);
      #1;
      if (model_en) begin
        if (i_dc_ready) begin
          i_dc_ready = 1'b0;
        end else if (o_dc_request && !cache_hold) begin
          wait_n++;
          if (wait_n >= cache_lat) begin
            wait_n = 0;
            i_dc_ready = 1'b1;
            if (o_dc_rw) begin
              mem[o_dc_address] = o_dc_wdata;
              wlog_a.push_back(o_dc_address);
              wlog_d.push_back(o_dc_wdata);
              wlog_c.push_back(cyc);
            end else begin
              i_dc_rdata = mem.exists(o_dc_address) ?
                           mem[o_dc_address] : '0;
              n_reads++;
            end
          end
        end else begin
          wait_n = 0;
        end
        if (o_dc_flush) begin
          n_flush++;
          flush_cyc  = cyc;
          flush_wlog = wlog_a.size();
        end
        if (n_acked - wlog_a.size() > max_out)
          max_out = n_acked - wlog_a.size();
      end
    end
  end

  task automatic cpu_write(input logic [AW-1:0] a,
                           input logic [DW-1:0] d,
                           input logic c,
                           output int ack_at,
                           output int lat);
    int t0, n;
    i_request = 1'b1; i_rw = 1'b1;
    i_address = a; i_wdata = d; i_cacheable = c;
    t0 = cyc; n = 0;
    do begin
      @(posedge i_clock); #1; n++;
    end while (!o_ready && n < 400);
    if (!o_ready) chk("wr_timeout", o_ready, 1);
    ack_at = cyc; lat = cyc - t0;
    n_acked++;
    ref_mem[a] = d;
    exp_a.push_back(a);
    exp_d.push_back(d);
    i_request = 1'b0; i_rw = 1'b0;
    @(posedge i_clock); #1;
    chk("wr_pulse", o_ready, 0);
  endtask

  task automatic cpu_read(input logic [AW-1:0] a,
                          input logic c,
                          output logic [DW-1:0] d,
                          output int lat);
    int t0, n;
    i_request = 1'b1; i_rw = 1'b0;
    i_address = a; i_cacheable = c;
    t0 = cyc; n = 0;
    do begin
      @(posedge i_clock); #1; n++;
    end while (!o_ready && n < 600);
    if (!o_ready) chk("rd_timeout", o_ready, 1);
    d = o_rdata; lat = cyc - t0;
    i_request = 1'b0;
    @(posedge i_clock); #1;
  endtask

  task automatic cpu_flush(output int ack_at);
    int n;
    i_flush = 1'b1; n = 0;
    do begin
      @(posedge i_clock); #1; n++;
    end while (!o_ready && n < 600);
    if (!o_ready) chk("fl_timeout", o_ready, 1);
    ack_at = cyc;
    i_flush = 1'b0;
    @(posedge i_clock); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(o_empty && wlog_a.size() == n_acked) && n < 2000) begin
      @(posedge i_clock); #1; n++;
    end
    if (n >= 2000) chk("idle_timeout", o_empty, 1);
  endtask

  int            ack, lat, ack5, lat5, r0, f0, base;
  logic [DW-1:0] rd;
  logic [AW-1:0] ra;
  logic [DW-1:0] t6_d [$];
  logic [AW-1:0] t6_a [$];

  initial begin
    repeat (3) @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    chk("rst_empty", o_empty, 1);
    chk("rst_dcreq", o_dc_request, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_flush", o_dc_flush, 0);
    chk("rst_rdata", o_rdata, 0);

    // Reset with stores buffered, then a stray cache ready
    cache_hold = 1'b1;
    cpu_write(32'h40, 32'h55, 1'b1, ack, lat);
    cpu_write(32'h44, 32'h66, 1'b1, ack, lat);
    chk("t1_dcreq_busy", o_dc_request, 1);
    chk("t1_empty_busy", o_empty, 0);
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    chk("t1_empty_rst", o_empty, 1);
    chk("t1_dcreq_rst", o_dc_request, 0);
    model_en = 1'b0;
    i_dc_ready = 1'b1;
    @(posedge i_clock); #1;
    i_dc_ready = 1'b0;
    repeat (3) @(posedge i_clock);
    #1;
    chk("t1_dcreq_late", o_dc_request, 0);
    chk("t1_empty_late", o_empty, 1);
    ref_mem.delete(); mem.delete();
    exp_a.delete(); exp_d.delete();
    wlog_a.delete(); wlog_d.delete(); wlog_c.delete();
    n_acked = 0; wait_n = 0;
    cache_hold = 1'b0; model_en = 1'b1;
    cpu_read(32'h40, 1'b1, rd, lat);
    chk("t1_discarded", rd, 0);

    // Five stores into a four-deep buffer with the cache held off
    cache_lat = 1; cache_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_write(32'h100 + 32'(4*i), DW'(i+1), 1'b1, ack, lat);
      chk("t2_lat", lat, 1);
    end
    fork
      cpu_write(32'h110, 32'd5, 1'b1, ack5, lat5);
      begin
        repeat (4) @(posedge i_clock);
        #1;
        cache_hold = 1'b0;
      end
    join
    chk("t2_stall", lat5 > 1, 1);
    chk("t2_stall_ack", ack5, wlog_c[0] + 2);
    wait_idle();
    chk("t2_count", wlog_a.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("t2_addr", wlog_a[i], 32'h100 + 32'(4*i));
      chk("t2_data", wlog_d[i], DW'(i+1));
    end

    // Store then load of the same word
    cache_lat = 10;
    cpu_write(32'h200, 32'hAA, 1'b1, ack, lat);
    r0 = n_reads;
    cpu_read(32'h200, 1'b1, rd, lat);
    chk("t3_data", rd, 32'hAA);
    chk("t3_reads", n_reads - r0, FWD ? 0 : 1);
    chk("t3_lat1", lat == 1, FWD);
    wait_idle();

    // Two stores to one word; the younger must win
    cpu_write(32'h300, 32'h11, 1'b1, ack, lat);
    cpu_write(32'h300, 32'h22, 1'b1, ack, lat);
    r0 = n_reads;
    cpu_read(32'h300, 1'b1, rd, lat);
    chk("t4_data", rd, 32'h22);
    chk("t4_reads", n_reads - r0, FWD ? 0 : 1);
    cpu_write(32'h304, 32'h33, 1'b1, ack, lat);
    chk("t4_rdata_held", o_rdata, 32'h22);
    wait_idle();

    // Flush ordering behind buffered stores
    cache_lat = 2;
    f0 = n_flush;
    cpu_write(32'h500, 32'h1, 1'b1, ack, lat);
    cpu_write(32'h504, 32'h2, 1'b0, ack, lat);
    cpu_flush(ack);
    chk("t5_pulses", n_flush - f0, 1);
    chk("t5_order", flush_wlog, n_acked);
    chk("t5_ack", ack, flush_cyc + 1);

    // Pointer wrap with back-to-back stores
    wait_idle();
    cache_lat = 1; max_out = 0;
    base = wlog_a.size();
    for (int i = 0; i < 3*DEPTH+1; i++) begin
      t6_a.push_back(AW'($urandom_range(0, 255)) << 2);
      t6_d.push_back(DW'($urandom));
      cpu_write(t6_a[i], t6_d[i], 1'b1, ack, lat);
    end
    wait_idle();
    chk("t6_max_out", max_out <= DEPTH, 1);
    for (int i = 0; i < 3*DEPTH+1; i++) begin
      chk("t6_addr", wlog_a[base+i], t6_a[i]);
      chk("t6_data", wlog_d[base+i], t6_d[i]);
    end

    // Random mix against program-order memory
    for (int i = 0; i < 60; i++) begin
      int op;
      cache_lat = $urandom_range(1, 4);
      op = $urandom_range(0, 5);
      ra = 32'h600 + (AW'($urandom_range(0, 3)) << 2);
      if (op <= 2) begin
        cpu_write(ra, DW'($urandom), 1'($urandom), ack, lat);
      end else if (op <= 4) begin
        cpu_read(ra, 1'($urandom), rd, lat);
        chk("rnd_read", rd,
            ref_mem.exists(ra) ? ref_mem[ra] : '0);
      end else begin
        cpu_flush(ack);
        chk("rnd_flush", flush_wlog, n_acked);
      end
    end

    wait_idle();
    chk("end_count", wlog_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) begin
      chk("end_addr", wlog_a[i], exp_a[i]);
      chk("end_data", wlog_d[i], exp_d[i]);
    end
    chk("end_empty", o_empty, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got cycle %0d expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
